// File: rtl/axis_upsizer_pkt.sv
// axis_upsizer_pkt: packet-aware AXI-Stream width upsizer.
// Packs RATIO narrow beats into one wide beat and flushes a partial wide beat
// early on tlast. Unfilled lanes leave with zero data and zero keep.
module axis_upsizer_pkt #(
    parameter int unsigned S_DATA_WIDTH = 8,
    parameter int unsigned RATIO        = 4,
    parameter int unsigned LANE_ORDER   = 0,
    parameter int unsigned M_DATA_WIDTH = S_DATA_WIDTH * RATIO,
    parameter int unsigned S_KEEP_WIDTH = S_DATA_WIDTH / 8,
    parameter int unsigned M_KEEP_WIDTH = M_DATA_WIDTH / 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,

    input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,

    output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready
);

    localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    out_state_t              out_state;

    logic [M_DATA_WIDTH-1:0] pack_data;
    logic [M_KEEP_WIDTH-1:0] pack_keep;
    logic [CNT_W-1:0]        cnt;

    logic [CNT_W-1:0]        lane;
    logic [M_DATA_WIDTH-1:0] merged_data;
    logic [M_KEEP_WIDTH-1:0] merged_keep;
    logic                    complete;
    logic                    s_acc;
    logic                    out_load;

    // Physical lane for the current beat; MSB-first order mirrors the counter.
    always_comb begin
        lane = cnt;
        if (LANE_ORDER != 0) begin
            lane = CNT_LAST - cnt;
        end
    end

    // Pack contents with the current input beat dropped into its lane.
    always_comb begin
        merged_data = pack_data;
        merged_keep = pack_keep;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (CNT_W'(i) == lane) begin
                merged_data[i*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis_tdata;
                merged_keep[i*S_KEEP_WIDTH +: S_KEEP_WIDTH] = s_axis_tkeep;
            end
        end
    end

    // A beat completes a wide word when it fills the last lane or ends the packet.
    // Only a completing beat needs room in the output stage, so only it can stall.
    always_comb begin
        complete      = (cnt == CNT_LAST) | s_axis_tlast;
        s_axis_tready = (out_state == ST_EMPTY) | m_axis_tready | ~complete;
        s_acc         = s_axis_tvalid & s_axis_tready;
        out_load      = s_acc & complete;
    end

    // Pack register: accumulate partial words, clear when a word is handed off.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pack_data <= '0;
            pack_keep <= '0;
            cnt       <= '0;
        end else if (s_acc) begin
            if (complete) begin
                pack_data <= '0;
                pack_keep <= '0;
                cnt       <= '0;
            end else begin
                pack_data <= merged_data;
                pack_keep <= merged_keep;
                cnt       <= cnt + CNT_W'(1);
            end
        end
    end

    // Output stage FSM: EMPTY/FULL with reload when a handshake and a load coincide.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_state     <= ST_EMPTY;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
        end else begin
            case (out_state)
                ST_EMPTY: begin
                    if (out_load) begin
                        out_state     <= ST_FULL;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= s_axis_tlast;
                        m_axis_tdata  <= merged_data;
                        m_axis_tkeep  <= merged_keep;
                    end
                end
                ST_FULL: begin
                    // A load here implies m_axis_tready, so held data never changes.
                    if (out_load) begin
                        out_state     <= ST_FULL;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= s_axis_tlast;
                        m_axis_tdata  <= merged_data;
                        m_axis_tkeep  <= merged_keep;
                    end else if (m_axis_tready) begin
                        out_state     <= ST_EMPTY;
                        m_axis_tvalid <= 1'b0;
                    end
                end
                default: begin
                    out_state     <= ST_EMPTY;
                    m_axis_tvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_upsizer_pkt.sv
// Self-checking bench for axis_upsizer_pkt: a reference packing model fills an
// expected-word queue per instance (LSB-first and MSB-first), monitors pop it.
module tb_axis_upsizer_pkt;

    localparam int unsigned SW     = 8;
    localparam int unsigned R      = 4;
    localparam int unsigned MW     = SW * R;
    localparam int unsigned MK     = MW / 8;
    localparam int          BUDGET = 20;

    typedef struct packed {
        logic [MW-1:0] data;
        logic [MK-1:0] keep;
        logic          last;
    } exp_t;

    logic          aclk;
    logic          aresetn;
    logic [SW-1:0] s_data;
    logic [0:0]    s_keep;
    logic          s_valid;
    logic          s_last;
    logic          s_ready0, s_ready1;
    logic [MW-1:0] m_data0, m_data1;
    logic [MK-1:0] m_keep0, m_keep1;
    logic          m_valid0, m_valid1;
    logic          m_last0, m_last1;
    logic          m_ready;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    logic [MW-1:0] md0, md1;
    logic [MK-1:0] mk0, mk1;
    int            mcnt;

    axis_upsizer_pkt #(.S_DATA_WIDTH(SW), .RATIO(R), .LANE_ORDER(0)) dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
        .s_axis_tlast(s_last), .s_axis_tready(s_ready0),
        .m_axis_tdata(m_data0), .m_axis_tkeep(m_keep0), .m_axis_tvalid(m_valid0),
        .m_axis_tlast(m_last0), .m_axis_tready(m_ready)
    );

    axis_upsizer_pkt #(.S_DATA_WIDTH(SW), .RATIO(R), .LANE_ORDER(1)) dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
        .s_axis_tlast(s_last), .s_axis_tready(s_ready1),
        .m_axis_tdata(m_data1), .m_axis_tkeep(m_keep1), .m_axis_tvalid(m_valid1),
        .m_axis_tlast(m_last1), .m_axis_tready(m_ready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Reference model: clear the partial word (reset or packet discard).
    task automatic model_reset();
        md0 = '0; md1 = '0; mk0 = '0; mk1 = '0; mcnt = 0;
        q0.delete();
        q1.delete();
    endtask

    // Reference model: one accepted beat, both lane orders.
    task automatic model_accept(input logic [SW-1:0] d, input logic k, input logic l);
        exp_t e;
        int   ln0, ln1;
        ln0 = mcnt;
        ln1 = R - 1 - mcnt;
        md0[ln0*SW +: SW] = d;
        mk0[ln0]          = k;
        md1[ln1*SW +: SW] = d;
        mk1[ln1]          = k;
        if (mcnt == R - 1 || l) begin
            e.data = md0; e.keep = mk0; e.last = l;
            q0.push_back(e);
            e.data = md1; e.keep = mk1; e.last = l;
            q1.push_back(e);
            md0 = '0; md1 = '0; mk0 = '0; mk1 = '0; mcnt = 0;
        end else begin
            mcnt++;
        end
    endtask

    // Output monitors: every handshaken word must match the head of its queue.
    always @(negedge aclk) begin
        exp_t e;
        if (aresetn && m_valid0 && m_ready) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL lsb_unexpected_word got %h/%h/%b, none expected", m_data0, m_keep0, m_last0);
            end else begin
                e = q0.pop_front();
                if (m_data0 !== e.data || m_keep0 !== e.keep || m_last0 !== e.last) begin
                    errors++;
                    $display("FAIL lsb_word got %h/%h/%b want %h/%h/%b",
                             m_data0, m_keep0, m_last0, e.data, e.keep, e.last);
                end
            end
        end
        if (aresetn && m_valid1 && m_ready) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL msb_unexpected_word got %h/%h/%b, none expected", m_data1, m_keep1, m_last1);
            end else begin
                e = q1.pop_front();
                if (m_data1 !== e.data || m_keep1 !== e.keep || m_last1 !== e.last) begin
                    errors++;
                    $display("FAIL msb_word got %h/%h/%b want %h/%h/%b",
                             m_data1, m_keep1, m_last1, e.data, e.keep, e.last);
                end
            end
        end
    end

    // Present one beat and hold it until accepted (bounded); reports stall cycles.
    task automatic send_beat(input logic [SW-1:0] d, input logic k, input logic l, output int waited);
        bit done;
        s_data = d; s_keep = k; s_last = l; s_valid = 1'b1;
        waited = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge aclk);
            if (s_ready0 === 1'b1) begin
                model_accept(d, k, l);
                @(posedge aclk);
                #1;
                done = 1'b1;
            end else begin
                waited++;
                if (waited > BUDGET) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout beat %h stalled %0d cycles, want accept within %0d", d, waited, BUDGET);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic idle();
        s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_keep = 1'b0;
    endtask

    // Wait (bounded) until every expected word has been observed.
    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            @(negedge aclk);
            n++;
        end
        @(posedge aclk); #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending %0d/%0d words, want 0/0", name, q0.size(), q1.size());
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0; m_ready = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge aclk);
        checks++;
        if (m_valid0 !== 1'b0 || m_last0 !== 1'b0 || m_data0 !== '0 || m_keep0 !== '0 || s_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got v=%b l=%b d=%h k=%h rdy=%b want 0 0 0 0 1",
                     m_valid0, m_last0, m_data0, m_keep0, s_ready0);
        end
        @(posedge aclk); #1;
        aresetn = 1'b1;
    endtask

    task automatic test_full_packet();
        int w;
        m_ready = 1'b1;
        send_beat(8'h11, 1'b1, 1'b0, w);
        send_beat(8'h22, 1'b1, 1'b0, w);
        send_beat(8'h33, 1'b1, 1'b0, w);
        send_beat(8'h44, 1'b1, 1'b1, w);
        idle();
        @(negedge aclk);
        checks++;
        if (m_valid0 !== 1'b1 || m_data0 !== 32'h44332211 || m_keep0 !== 4'hF || m_last0 !== 1'b1) begin
            errors++;
            $display("FAIL full_packet got v=%b d=%h k=%h l=%b want 1 44332211 f 1",
                     m_valid0, m_data0, m_keep0, m_last0);
        end
        @(negedge aclk);
        checks++;
        if (m_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL full_packet_one_cycle valid=%b on second cycle, want 0", m_valid0);
        end
        wait_drain("full_packet");
    endtask

    task automatic test_short_tail();
        int w;
        m_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            send_beat(SW'(i), 1'b1, (i == 6), w);
        end
        idle();
        wait_drain("short_tail");
    endtask

    task automatic test_backpressure();
        int w;
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send_beat(8'hA0 + SW'(i), 1'b1, 1'b0, w);
        end
        fork
            send_beat(8'hA7, 1'b1, 1'b0, w);
            begin
                repeat (3) begin
                    @(negedge aclk);
                    checks++;
                    if (s_ready0 !== 1'b0 || m_valid0 !== 1'b1 || m_data0 !== 32'hA3A2A1A0) begin
                        errors++;
                        $display("FAIL backpressure_hold got rdy=%b v=%b d=%h want 0 1 a3a2a1a0",
                                 s_ready0, m_valid0, m_data0);
                    end
                end
                @(posedge aclk); #1;
                m_ready = 1'b1;
            end
        join
        idle();
        wait_drain("backpressure");
    endtask

    task automatic test_lane_order();
        int w;
        m_ready = 1'b1;
        send_beat(8'h11, 1'b1, 1'b0, w);
        send_beat(8'h22, 1'b1, 1'b0, w);
        send_beat(8'h33, 1'b1, 1'b0, w);
        send_beat(8'h44, 1'b1, 1'b1, w);
        idle();
        @(negedge aclk);
        checks++;
        if (m_valid1 !== 1'b1 || m_data1 !== 32'h11223344 || m_keep1 !== 4'hF) begin
            errors++;
            $display("FAIL lane_order got v=%b d=%h k=%h want 1 11223344 f", m_valid1, m_data1, m_keep1);
        end
        wait_drain("lane_order");
    endtask

    task automatic test_reset_mid_packet();
        int w;
        m_ready = 1'b1;
        send_beat(8'h55, 1'b1, 1'b0, w);
        send_beat(8'h66, 1'b1, 1'b0, w);
        idle();
        aresetn = 1'b0;
        model_reset();
        repeat (2) begin
            @(negedge aclk);
            checks++;
            if (m_valid0 !== 1'b0 || m_last0 !== 1'b0 || m_data0 !== '0 || m_keep0 !== '0 ||
                m_data1 !== '0 || m_keep1 !== '0) begin
                errors++;
                $display("FAIL reset_mid_outputs got v=%b l=%b d=%h k=%h d1=%h k1=%h want all 0",
                         m_valid0, m_last0, m_data0, m_keep0, m_data1, m_keep1);
            end
        end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send_beat(SW'(i), 1'b1, (i == 4), w);
        end
        idle();
        @(negedge aclk);
        checks++;
        if (m_valid0 !== 1'b1 || m_data0 !== 32'h04030201 || m_keep0 !== 4'hF) begin
            errors++;
            $display("FAIL reset_mid_next got v=%b d=%h k=%h want 1 04030201 f", m_valid0, m_data0, m_keep0);
        end
        wait_drain("reset_mid");
    endtask

    task automatic test_stream();
        int          w;
        int          gap;
        logic [SW-1:0] d;
        logic        k;
        logic        l;
        m_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            gap = $urandom_range(0, 2);
            idle();
            for (int g = 0; g < gap; g++) begin
                @(negedge aclk);
                checks++;
                if (s_ready0 !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_idle_ready beat %0d got %b want 1", i, s_ready0);
                end
                @(posedge aclk); #1;
            end
            d = SW'($urandom);
            k = (i == 63) ? 1'b1 : 1'($urandom_range(0, 1));
            l = ((i % 7) == 6) || (i == 63);
            send_beat(d, k, l, w);
            checks++;
            if (w != 0) begin
                errors++;
                $display("FAIL stream_ready beat %0d stalled %0d cycles want 0", i, w);
            end
        end
        idle();
        @(negedge aclk);
        checks++;
        if (m_valid0 !== 1'b1 || m_keep0 !== 4'h1 || m_last0 !== 1'b1) begin
            errors++;
            $display("FAIL single_beat got v=%b k=%h l=%b want 1 1 1", m_valid0, m_keep0, m_last0);
        end
        wait_drain("stream");
    endtask

    initial begin
        test_reset();
        test_full_packet();
        test_short_tail();
        test_backpressure();
        test_lane_order();
        test_reset_mid_packet();
        test_stream();
        repeat (3) @(posedge aclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
